// File: rtl/bicubic_pkg.sv
// Shared constants, FSM encoding and index helpers for the bicubic window buffer.
package bicubic_pkg;

  localparam int CHANNEL_WIDTH = 8;
  localparam int NUM_SLOTS     = 5;
  localparam int SLOT_W        = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRIME   = 2'd1,
    RUN     = 2'd2,
    ROW_END = 2'd3
  } state_t;

  // Edge replication: clamp v into 0..lim-1.
  function automatic int clamp_idx(input int v, input int lim);
    if (v < 0)            return 0;
    else if (v > lim - 1) return lim - 1;
    else                  return v;
  endfunction

  // Bits needed to hold the values 0..n-1.
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic logic [SLOT_W-1:0] slot_of(input int row);
    return SLOT_W'(row % NUM_SLOTS);
  endfunction

endpackage

// File: rtl/bicubic_line_ram.sv
// One source line of storage: simple dual-port RAM with a registered read port.
module bicubic_line_ram
  import bicubic_pkg::*;
#(
  parameter int  DEPTH = 960,
  parameter int  WIDTH = CHANNEL_WIDTH,
  localparam int AW    = idx_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the storage array is deliberately not reset; only the read register is,
  // so it maps onto block RAM and every row is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // The read register holds its value while re is low, so a stalled window stays put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/bicubic_window_buffer.sv
// Five-line ring buffer producing one 4x4 neighbourhood per source pixel in raster order.
// Define BICUBIC_WINDOW_ZERO_PAD_EN to read out-of-frame taps as 0 instead of edge-replicating.
module bicubic_window_buffer
  import bicubic_pkg::*;
#(
  parameter int IMG_WIDTH  = 960,
  parameter int IMG_HEIGHT = 540
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ac_req_valid,
  output logic                     bf_req_ready,
  input  logic [CHANNEL_WIDTH-1:0] ac_req_data,
  output logic                     bf_req_valid,
  input  logic                     bcci_req_ready,
  output logic [CHANNEL_WIDTH-1:0] p1,  p2,  p3,  p4,
  output logic [CHANNEL_WIDTH-1:0] p5,  p6,  p7,  p8,
  output logic [CHANNEL_WIDTH-1:0] p9,  p10, p11, p12,
  output logic [CHANNEL_WIDTH-1:0] p13, p14, p15, p16
);

  localparam int CW = idx_width(IMG_WIDTH);
  localparam int XW = idx_width(IMG_WIDTH + 1);
  localparam int YW = idx_width(IMG_HEIGHT);

  // Writer
  logic [CW-1:0]     wcol;
  logic [YW-1:0]     wrow;
  logic [SLOT_W-1:0] wslot;
  logic              wr_done;
  logic              alive;
  logic              in_hs;

  // Reader
  state_t            state, state_nxt;
  logic [XW-1:0]     ox;
  logic [YW-1:0]     oy;
  logic [1:0]        pcnt;
  logic              win_valid;
  logic              out_hs, advance, all_issued, row_done_hs, frame_done_hs, row_ready;
  logic              rd_en;
  logic [CW-1:0]     rd_col;
  int                row_lim, need_row;

  logic [SLOT_W-1:0]        row_slot [4];
  logic [NUM_SLOTS-1:0]     slot_used, ram_we, ram_re;
  logic [CHANNEL_WIDTH-1:0] ram_q   [NUM_SLOTS];
  logic [CHANNEL_WIDTH-1:0] new_col [4];
  logic [CHANNEL_WIDTH-1:0] col_q   [3][4];
  logic [CHANNEL_WIDTH-1:0] win     [16];

  // Writer may run at most to row max(oy-1,0)+4, the slot output row oy no longer needs.
  always_comb begin
    row_lim  = ((oy == '0) ? 0 : int'(oy) - 1) + 4;
    need_row = clamp_idx(int'(oy) + 2, IMG_HEIGHT);
  end

  assign bf_req_ready = alive && !wr_done && (int'(wrow) <= row_lim);
  assign in_hs        = ac_req_valid && bf_req_ready;
  assign row_ready    = wr_done || (int'(wrow) > need_row);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcol    <= '0;
      wrow    <= '0;
      wslot   <= '0;
      wr_done <= 1'b0;
      alive   <= 1'b0;
    end else begin
      alive <= 1'b1;
      if (in_hs) begin
        if (wcol == CW'(IMG_WIDTH - 1)) begin
          wcol <= '0;
          if (wrow == YW'(IMG_HEIGHT - 1)) begin
            wrow    <= '0;
            wslot   <= '0;
            wr_done <= 1'b1;
          end else begin
            wrow  <= wrow + YW'(1);
            wslot <= (wslot == SLOT_W'(NUM_SLOTS - 1)) ? '0 : wslot + SLOT_W'(1);
          end
        end else begin
          wcol <= wcol + CW'(1);
        end
      end
      // The next frame may only start once the reader has handed off its last window.
      if (frame_done_hs) wr_done <= 1'b0;
    end
  end

  // Rows y-1..y+2 of the current output row, clamped, mapped onto ring slots.
  always_comb begin
    logic [SLOT_W-1:0] s;
    slot_used = '0;
    for (int r = 0; r < 4; r++) begin
      s           = slot_of(clamp_idx(int'(oy) - 1 + r, IMG_HEIGHT));
      row_slot[r] = s;
      slot_used[s] = 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_ram
    assign ram_we[i] = in_hs && (wslot == SLOT_W'(i));
    assign ram_re[i] = rd_en && slot_used[i];

    bicubic_line_ram #(
      .DEPTH (IMG_WIDTH),
      .WIDTH (CHANNEL_WIDTH)
    ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (ram_we[i]),
      .waddr (wcol),
      .wdata (ac_req_data),
      .re    (ram_re[i]),
      .raddr (rd_col),
      .rdata (ram_q[i])
    );

    a_no_collision: assert property (@(posedge clk) disable iff (!rst_n)
      !(ram_we[i] && ram_re[i] && (wcol == rd_col)));
  end

  assign out_hs        = win_valid && bcci_req_ready;
  assign advance       = !win_valid || bcci_req_ready;
  assign all_issued    = (ox == XW'(IMG_WIDTH));
  assign row_done_hs   = all_issued && out_hs;
  assign frame_done_hs = (state == RUN) && row_done_hs && (oy == YW'(IMG_HEIGHT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (row_ready) state_nxt = PRIME;
      PRIME:   if (pcnt == 2'd2) state_nxt = RUN;
      RUN:     if (row_done_hs) state_nxt = ROW_END;
      ROW_END: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    rd_en  = 1'b0;
    rd_col = '0;
    case (state)
      PRIME: begin
        rd_en  = 1'b1;
        rd_col = (pcnt == 2'd2) ? CW'(1) : '0;
      end
      RUN: begin
        if (!all_issued && advance) begin
          rd_en  = 1'b1;
          rd_col = CW'(clamp_idx(int'(ox) + 2, IMG_WIDTH));
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ox        <= '0;
      oy        <= '0;
      pcnt      <= '0;
      win_valid <= 1'b0;
    end else begin
      pcnt <= (state == PRIME) ? pcnt + 2'd1 : 2'd0;
      if (state == RUN && rd_en) begin
        ox        <= ox + XW'(1);
        win_valid <= 1'b1;
      end else if (out_hs) begin
        win_valid <= 1'b0;
      end
      if (state == ROW_END) begin
        ox <= '0;
        oy <= (oy == YW'(IMG_HEIGHT - 1)) ? '0 : oy + YW'(1);
      end
    end
  end

  // Column 3 of the window is the RAM read register itself; older columns shift behind it.
  always_comb begin
    for (int r = 0; r < 4; r++) new_col[r] = ram_q[row_slot[r]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 3; c++)
        for (int r = 0; r < 4; r++) col_q[c][r] <= '0;
    end else if (rd_en) begin
      for (int r = 0; r < 4; r++) begin
        col_q[0][r] <= col_q[1][r];
        col_q[1][r] <= col_q[2][r];
        col_q[2][r] <= new_col[r];
      end
    end
  end

`ifdef BICUBIC_WINDOW_ZERO_PAD_EN
  logic [CW-1:0] win_x;
  logic [YW-1:0] win_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_x <= '0;
      win_y <= '0;
    end else if (state == RUN && rd_en) begin
      win_x <= CW'(ox);
      win_y <= oy;
    end
  end

  always_comb begin
    int yy, xx;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        yy = int'(win_y) - 1 + r;
        xx = int'(win_x) - 1 + c;
        win[4*r+c] = (c < 3) ? col_q[c][r] : new_col[r];
        if (yy < 0 || yy >= IMG_HEIGHT || xx < 0 || xx >= IMG_WIDTH) win[4*r+c] = '0;
      end
    end
  end
`else
  always_comb begin
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) win[4*r+c] = (c < 3) ? col_q[c][r] : new_col[r];
  end
`endif

  assign bf_req_valid = win_valid;

  assign p1  = win[0];
  assign p2  = win[1];
  assign p3  = win[2];
  assign p4  = win[3];
  assign p5  = win[4];
  assign p6  = win[5];
  assign p7  = win[6];
  assign p8  = win[7];
  assign p9  = win[8];
  assign p10 = win[9];
  assign p11 = win[10];
  assign p12 = win[11];
  assign p13 = win[12];
  assign p14 = win[13];
  assign p15 = win[14];
  assign p16 = win[15];

endmodule

// File: tb/tb_bicubic_window_buffer.sv
// Randomized bench for bicubic_window_buffer against a frame-array reference model.
module tb_bicubic_window_buffer;

  localparam int W  = 4;
  localparam int H  = 8;
  localparam int CH = 8;

  typedef logic [15:0][CH-1:0] win_t;
  typedef struct { win_t w; int f; int x; int y; } exp_t;
  typedef struct { logic [CH-1:0] d; int need_out; } px_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ac_req_valid, bcci_req_ready;
  logic [CH-1:0] ac_req_data;
  logic          bf_req_ready, bf_req_valid;
  logic [CH-1:0] p1, p2, p3, p4, p5, p6, p7, p8, p9, p10, p11, p12, p13, p14, p15, p16;
  win_t          cur_win;

  px_t  src_q [$];
  exp_t exp_q [$];
  int   frame_buf [H][W];
  win_t first_win [8];
  win_t last_win, held_win;
  bit   held;
  int   n_vec, n_err, n_in, n_out, n_frames, vpct, rpct;

`ifdef BICUBIC_WINDOW_ZERO_PAD_EN
  int corner_v [16] = '{0, 0, 0, 0,  0, 0, 1, 2,  0, 16, 17, 18,  0, 32, 33, 34};
  int last_v   [16] = '{98, 99, 0, 0,  114, 115, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0};
`else
  int corner_v [16] = '{0, 0, 1, 2,  0, 0, 1, 2,  16, 16, 17, 18,  32, 32, 33, 34};
  int last_v   [16] = '{98, 99, 99, 99,  114, 115, 115, 115,  114, 115, 115, 115,  114, 115, 115, 115};
`endif

  always #5 clk = ~clk;

  bicubic_window_buffer #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ac_req_valid   (ac_req_valid),
    .bf_req_ready   (bf_req_ready),
    .ac_req_data    (ac_req_data),
    .bf_req_valid   (bf_req_valid),
    .bcci_req_ready (bcci_req_ready),
    .p1 (p1),   .p2 (p2),   .p3 (p3),   .p4 (p4),
    .p5 (p5),   .p6 (p6),   .p7 (p7),   .p8 (p8),
    .p9 (p9),   .p10(p10),  .p11(p11),  .p12(p12),
    .p13(p13),  .p14(p14),  .p15(p15),  .p16(p16)
  );

  assign cur_win = {p16, p15, p14, p13, p12, p11, p10, p9, p8, p7, p6, p5, p4, p3, p2, p1};

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int clampi(input int v, input int lim);
    return (v < 0) ? 0 : ((v > lim - 1) ? lim - 1 : v);
  endfunction

  function automatic win_t pack16(input int v [16]);
    win_t w;
    for (int k = 0; k < 16; k++) w[k] = CH'(v[k]);
    return w;
  endfunction

  // Window (x,y) straight from the stored source frame.
  function automatic win_t calc_win(input int x, input int y);
    win_t w;
    int   yy, xx;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        yy = y - 1 + r;
        xx = x - 1 + c;
`ifdef BICUBIC_WINDOW_ZERO_PAD_EN
        if (yy < 0 || yy >= H || xx < 0 || xx >= W) w[4*r+c] = '0;
        else w[4*r+c] = CH'(frame_buf[yy][xx]);
`else
        w[4*r+c] = CH'(frame_buf[clampi(yy, H)][clampi(xx, W)]);
`endif
      end
    end
    return w;
  endfunction

  // kind 0: ramp 16y+x+off, kind 1: random pixels.
  task automatic push_frame(input int kind, input int off);
    px_t  px;
    exp_t e;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        frame_buf[y][x] = (kind == 0) ? (16 * y + x + off) : int'($urandom_range(255));
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        px.d        = CH'(frame_buf[y][x]);
        px.need_out = (x == 0 && y == 0) ? n_frames * W * H : 0;
        src_q.push_back(px);
      end
    end
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        e.w = calc_win(x, y);
        e.f = n_frames;
        e.x = x;
        e.y = y;
        exp_q.push_back(e);
      end
    end
    n_frames++;
  endtask

  // One clock: sample both handshakes at the falling edge, then drive new inputs.
  task automatic tick();
    px_t  px;
    exp_t e;
    @(negedge clk);
    if (ac_req_valid && bf_req_ready) begin
      px = src_q.pop_front();
      if (px.need_out > 0) check("frame_order", n_out >= px.need_out, 1);
      n_in++;
    end
    if (held) begin
      check("held_valid", bf_req_valid, 1);
      check("held_stable", cur_win, held_win);
    end
    if (bf_req_valid && bcci_req_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_window", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("win f%0d x%0d y%0d", e.f, e.x, e.y), cur_win, e.w);
        if (e.x == 0 && e.y == 0) first_win[e.f] = cur_win;
      end
      last_win = cur_win;
      n_out++;
      held = 1'b0;
    end else if (bf_req_valid) begin
      held     = 1'b1;
      held_win = cur_win;
    end else begin
      held = 1'b0;
    end
    @(posedge clk);
    #1;
    ac_req_valid   = (src_q.size() != 0) && ($urandom_range(99) < vpct);
    ac_req_data    = (src_q.size() != 0) ? src_q[0].d : '0;
    bcci_req_ready = ($urandom_range(99) < rpct);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check("drain_done", (src_q.size() == 0) && (exp_q.size() == 0), 1);
  endtask

  initial begin
    n_vec = 0; n_err = 0; n_in = 0; n_out = 0; n_frames = 0; held = 1'b0;
    ac_req_valid = 1'b0; ac_req_data = '0; bcci_req_ready = 1'b0; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_valid", bf_req_valid, 0);
    check("rst_window", cur_win, 0);
    @(negedge clk);
    check("rst_ready", bf_req_ready, 1);
    @(posedge clk);
    #1;

    // Downstream stalled: writer must stop 4 rows ahead of output row 0.
    vpct = 100; rpct = 0;
    push_frame(0, 0);
    repeat (40) tick();
    check("stall_accepted", n_in, 20);
    check("stall_ready", bf_req_ready, 0);
    check("stall_valid", bf_req_valid, 1);
    check("corner_first", cur_win, pack16(corner_v));
    rpct = 100;
    drain(2000);
    check("frame0_count", n_out, W * H);
    check("corner_last", last_win, pack16(last_v));

    // Back-to-back frames, second one offset by 100.
    vpct = 100; rpct = 50;
    push_frame(0, 0);
    push_frame(0, 100);
    drain(4000);
    check("f2_p6", first_win[2][5], 100);

    // Random pixels with random gaps and back-pressure.
    vpct = 70; rpct = 50;
    push_frame(1, 0);
    push_frame(1, 0);
    drain(4000);
    check("epoch_count", n_out, 5 * W * H);

    // Reset after 7 pixels, then a fresh frame.
    vpct = 100; rpct = 100; n_in = 0;
    push_frame(0, 0);
    for (int n = 0; n < 100 && n_in < 7; n++) tick();
    check("pre_reset_in", n_in, 7);
    rst_n = 1'b0;
    ac_req_valid = 1'b0;
    src_q.delete();
    exp_q.delete();
    n_out = 0; n_frames = 0; n_in = 0; held = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("reset_valid", bf_req_valid, 0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    push_frame(0, 0);
    drain(2000);
    check("post_reset_first", first_win[0], pack16(corner_v));
    check("post_reset_count", n_out, W * H);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bicubic_window_buffer.md
# bicubic_window_buffer

Upstream feeder of the bicubic 4x4 upsampler. It accepts the source image as a raster pixel stream of one channel and stores it in a five-line ring buffer. For every source pixel (x,y) it presents one 4x4 neighbourhood window on p1..p16, using the rows y-1..y+2 and columns x-1..x+2. Windows are emitted in raster order under a valid/ready handshake; taps outside the frame are edge-replicated.

## Interface
- CHANNEL_WIDTH, 8, bits per pixel channel
- IMG_WIDTH, 960, source pixels per line (≥4)
- IMG_HEIGHT, 540, source lines per frame (≥4)
- clk  in  1  sole clock
- rst_n  in  1  reset, asynchronous, active-low
- ac_req_valid  in  1  source pixel valid
- bf_req_ready  out  1  source pixel accepted this cycle when high with ac_req_valid
- ac_req_data  in  CHANNEL_WIDTH  source pixel, raster order, frame boundaries implied by IMG_WIDTH/IMG_HEIGHT
- bf_req_valid  out  1  window valid
- bcci_req_ready  in  1  downstream accepts window
- p1..p16  out  CHANNEL_WIDTH each  window, row-major: p(4r+c+1) = pixel(clamp(y-1+r), clamp(x-1+c)), r,c∈0..3

## Operation
- Input side: each input handshake writes one pixel into line slot (row mod 5) at column wcol. wcol wraps at IMG_WIDTH−1 and then wrow increments; wrow wraps at IMG_HEIGHT−1 to 0, which starts the next frame.
- bf_req_ready = 1 iff the written row is at most max(oy−1,0)+4, where oy is the current output row. This stops the writer from overwriting a row that output row oy still needs. At frame wrap, bf_req_ready stays low until the last window of the frame has been handshaked.
- Output row oy may start once line min(oy+2, IMG_HEIGHT−1) is completely written.
- Clamp: clamp(v) = min(max(v,0), lim−1), where lim is IMG_WIDTH for columns and IMG_HEIGHT for rows.
- FSM states:
  - IDLE: waits until row oy is ready, then moves to PRIME.
  - PRIME: 3 cycles. Reads columns clamp(−1), 0, 1 into the 4-column shift window, then moves to RUN.
  - RUN: each advance reads column clamp(ox+2) from the four row slots and shifts it in. Presents window ox.
  - ROW_END: reached after window IMG_WIDTH−1 is handshaked. Increments oy and returns to IDLE. After the last row of the frame, oy and ox reset to 0.
- The window register advances only when it is empty or when bf_req_valid & bcci_req_ready. Otherwise p1..p16 and bf_req_valid are held stable.
- Row slots are selected as clamp(oy−1+r) mod 5.

## Timing
- Reset values:
  - bf_req_valid = 0, p1..p16 = 0.
  - bf_req_ready = 1 one cycle after reset release.
  - All counters = 0, FSM = IDLE.
- Line RAM read latency is 1 cycle. The first window of a row is valid 4 cycles after the FSM enters PRIME (3 prime reads + 1 read latency).
- Steady-state throughput in RUN is 1 window per cycle while bcci_req_ready = 1 and no row dependency is pending.
- A write and a read to the same slot and column in the same cycle cannot occur by construction. The verifier checks this with an assertion.
- Asserting rst_n low mid-frame discards all stored lines and any pending window. The next accepted pixel is treated as pixel (0,0).
- Input and output handshakes in the same cycle are independent and both take effect.

## Configuration
- BICUBIC_WINDOW_ZERO_PAD_EN
  - Defined: taps whose unclamped row or column lies outside the frame read as 0.
  - Undefined (default): those taps are edge-replicated via clamp.
  - Handshake, latency and ordering are identical in both builds.

## Structure
- Package bicubic_pkg holds:
  - CHANNEL_WIDTH
  - the line-slot count 5
  - FSM state encodings (IDLE, PRIME, RUN, ROW_END), 2-bit
  - the clamp width helpers
- Sub-module bicubic_line_ram: a simple dual-port RAM, IMG_WIDTH x CHANNEL_WIDTH, with 1 write port and 1 read port and a 1-cycle registered read. It is instantiated 5 times.

## Test plan
- Corner window, IMG_WIDTH=IMG_HEIGHT=4, pixel = 16y+x, bcci_req_ready=1 → first window:
  - p1..p4 = 0,0,1,2; p5..p8 = 0,0,1,2
  - p9..p12 = 16,16,17,18; p13..p16 = 32,32,33,34
- Same frame, last window (3,3) → p1..p4 = 34,35,35,35; p5..p16 = 50,51,51,51 repeated three times. Exactly 16 windows are emitted, in raster order.
- Random back-pressure on bcci_req_ready (50%) → p1..p16 are stable while valid & !ready. No window is dropped or duplicated against the reference model. bf_req_ready deasserts once the writer is 4 rows ahead.
- Build with BICUBIC_WINDOW_ZERO_PAD_EN on the 4x4 ramp → first window:
  - p1..p4 = 0; p5..p8 = 0,0,1,2
  - p9..p12 = 0,16,17,18; p13..p16 = 0,32,33,34
- Two back-to-back frames with the second frame's pixels offset +100 → frame 2 window (0,0) has p6=100. The first frame-2 pixel is accepted only after the frame-1 last window is handshaked.
- Pull rst_n low after 7 input pixels, then send a fresh frame → bf_req_valid=0 during reset, and the first window matches the corner-window values above.
